// File: rtl/sram_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : sram_frame_writer
//  Purpose  : Ingress frame writer in front of a 16K x 16 SRAM. Stores each
//             frame of a 16-bit word stream contiguously in a circular buffer
//             through SRAM port A and emits one descriptor (start address,
//             byte length) per stored frame. Frames are refused at SOP when
//             free space is below MAX_WORDS, and aborted when they exceed
//             MAX_WORDS words. Free space is returned by the downstream reader.
//  Ports    :
//    iClk, iRst              clock, synchronous active-high reset
//    iValid/oReady           ingress beat handshake
//    iData, iSop, iEop, iOdd ingress word, frame delimiters, odd-byte flag
//    oCEnA/oWEnA/oBWEnA      SRAM port A controls (active-low, registered)
//    oAddrA/oWDataA          SRAM port A address and write data
//    oDescValid/iDescReady   descriptor handshake
//    oDescAddr/oDescLen      frame start word address, length in bytes
//    iFreeValid/iFreeWords   words released by the reader
//    oFreeWords              current free words (0..2**AW)
//    oDropCnt                saturating count of refused/aborted frames
//  Revision : 1.0 - initial release
// ============================================================================
module sram_frame_writer #(
    parameter int AW        = 14,
    parameter int DW        = 16,
    parameter int MAX_WORDS = 1024
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic                          iValid,
    input  logic [DW-1:0]                 iData,
    input  logic                          iSop,
    input  logic                          iEop,
    input  logic                          iOdd,
    output logic                          oReady,
    output logic                          oCEnA,
    output logic                          oWEnA,
    output logic [DW-1:0]                 oBWEnA,
    output logic [AW-1:0]                 oAddrA,
    output logic [DW-1:0]                 oWDataA,
    output logic                          oDescValid,
    input  logic                          iDescReady,
    output logic [AW-1:0]                 oDescAddr,
    output logic [$clog2(MAX_WORDS)+1:0]  oDescLen,
    input  logic                          iFreeValid,
    input  logic [$clog2(MAX_WORDS):0]    iFreeWords,
    output logic [AW:0]                   oFreeWords,
    output logic [15:0]                   oDropCnt
);

    // Word counter must hold MAX_WORDS itself.
    localparam int c_CW = $clog2(MAX_WORDS) + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WRITE = 2'd1;
    localparam logic [1:0] c_DROP  = 2'd2;
    localparam logic [1:0] c_DESC  = 2'd3;

    localparam logic [AW+1:0]  c_FREE_MAX = {2'b01, {AW{1'b0}}};
    localparam logic [AW:0]    c_ADMIT    = (AW+1)'(MAX_WORDS);
    localparam logic [c_CW-1:0] c_MAX_CNT = c_CW'(MAX_WORDS);
    // Odd last word: only the first byte (upper half) is written.
    localparam logic [DW-1:0]  c_BWE_ODD  = {{(DW/2){1'b0}}, {(DW/2){1'b1}}};

    logic [1:0]       r_state;
    logic [1:0]       w_nextState;
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_startPtr;
    logic [c_CW-1:0]  r_wordCnt;
    logic [AW:0]      r_free;
    logic [15:0]      r_dropCnt;

    logic             w_accept;
    logic             w_admit;
    logic             w_full;
    logic             w_startFrame;
    logic             w_writeBeat;
    logic             w_abort;
    logic             w_refuse;
    logic             w_handshake;
    logic [c_CW-1:0]  w_wordCntNext;
    logic [c_CW:0]    w_lenBytes;
    logic [AW-1:0]    w_frameStart;
    logic [AW+1:0]    w_freeSum;

    assign w_accept     = iValid & oReady;
    assign w_admit      = (r_free >= c_ADMIT);
    assign w_full       = (r_wordCnt == c_MAX_CNT);
    assign w_startFrame = (r_state == c_IDLE) && w_accept && iSop && w_admit;
    assign w_refuse     = (r_state == c_IDLE) && w_accept && iSop && !w_admit;
    assign w_abort      = (r_state == c_WRITE) && w_accept && w_full;
    assign w_writeBeat  = w_startFrame || ((r_state == c_WRITE) && w_accept && !w_full);
    assign w_handshake  = (r_state == c_DESC) && iDescReady;

    assign w_wordCntNext = (r_state == c_IDLE) ? c_CW'(1) : (r_wordCnt + c_CW'(1));
    assign w_lenBytes    = {w_wordCntNext, 1'b0} - {{c_CW{1'b0}}, iOdd};
    assign w_frameStart  = (r_state == c_IDLE) ? r_wrPtr : r_startPtr;

    // Release and commit may coincide; both apply before saturation.
    assign w_freeSum = {1'b0, r_free}
                     + (iFreeValid  ? (AW+2)'(iFreeWords) : '0)
                     - (w_handshake ? (AW+2)'(r_wordCnt)  : '0);

    assign oFreeWords = r_free;
    assign oDropCnt   = r_dropCnt;

    // ---------------- state register ----------------
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept && iSop) begin
                    if (w_admit) begin
                        w_nextState = iEop ? c_DESC : c_WRITE;
                    end else begin
                        w_nextState = iEop ? c_IDLE : c_DROP;
                    end
                end
            end
            c_WRITE: begin
                if (w_accept) begin
                    if (w_full) begin
                        w_nextState = iEop ? c_IDLE : c_DROP;
                    end else if (iEop) begin
                        w_nextState = c_DESC;
                    end
                end
            end
            c_DROP: begin
                if (w_accept && iEop) begin
                    w_nextState = c_IDLE;
                end
            end
            c_DESC: begin
                if (iDescReady) begin
                    w_nextState = c_IDLE;
                end
            end
            default: w_nextState = c_IDLE;
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        oReady     = 1'b0;
        oDescValid = 1'b0;
        case (r_state)
            c_DESC:  oDescValid = 1'b1;
            default: oReady     = !iRst;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oCEnA      <= 1'b1;
            oWEnA      <= 1'b1;
            oBWEnA     <= '1;
            oAddrA     <= '0;
            oWDataA    <= '0;
            oDescAddr  <= '0;
            oDescLen   <= '0;
            r_wrPtr    <= '0;
            r_startPtr <= '0;
            r_wordCnt  <= '0;
            r_free     <= c_FREE_MAX[AW:0];
            r_dropCnt  <= '0;
        end else begin
            // Idle SRAM cycles present the reset values.
            oCEnA   <= 1'b1;
            oWEnA   <= 1'b1;
            oBWEnA  <= '1;
            oAddrA  <= '0;
            oWDataA <= '0;

            if (w_writeBeat) begin
                oCEnA     <= 1'b0;
                oWEnA     <= 1'b0;
                oAddrA    <= r_wrPtr;
                oWDataA   <= iData;
                oBWEnA    <= (iEop && iOdd) ? c_BWE_ODD : '0;
                r_wrPtr   <= r_wrPtr + AW'(1);
                r_wordCnt <= w_wordCntNext;
                // Descriptor fields are latched on the EOP beat and then
                // held for the whole DESC state.
                if (iEop) begin
                    oDescAddr <= w_frameStart;
                    oDescLen  <= w_lenBytes;
                end
            end

            if (w_startFrame) begin
                r_startPtr <= r_wrPtr;
            end

            // Oversize frame: rewind so the next frame reuses the space.
            if (w_abort) begin
                r_wrPtr <= r_startPtr;
            end

            if ((w_abort || w_refuse) && (r_dropCnt != 16'hffff)) begin
                r_dropCnt <= r_dropCnt + 16'd1;
            end

            r_free <= (w_freeSum > c_FREE_MAX) ? c_FREE_MAX[AW:0] : w_freeSum[AW:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_frame_writer
//  Purpose  : Scoreboard bench for sram_frame_writer. A frame-level model
//             (pointer, free space, drop count) pushes expected SRAM writes
//             and descriptors into queues; a monitor pops and compares them
//             whenever the DUT presents a write or a descriptor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_frame_writer;

    localparam int DEPTH = 16384;
    localparam int MAXW  = 1024;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iValid = 1'b0;
    logic [15:0] iData = 16'h0000;
    logic        iSop = 1'b0;
    logic        iEop = 1'b0;
    logic        iOdd = 1'b0;
    logic        iDescReady = 1'b0;
    logic        iFreeValid = 1'b0;
    logic [10:0] iFreeWords = 11'd0;

    logic        oReady;
    logic        oCEnA;
    logic        oWEnA;
    logic [15:0] oBWEnA;
    logic [13:0] oAddrA;
    logic [15:0] oWDataA;
    logic        oDescValid;
    logic [13:0] oDescAddr;
    logic [11:0] oDescLen;
    logic [14:0] oFreeWords;
    logic [15:0] oDropCnt;

    sram_frame_writer dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iValid     (iValid),
        .iData      (iData),
        .iSop       (iSop),
        .iEop       (iEop),
        .iOdd       (iOdd),
        .oReady     (oReady),
        .oCEnA      (oCEnA),
        .oWEnA      (oWEnA),
        .oBWEnA     (oBWEnA),
        .oAddrA     (oAddrA),
        .oWDataA    (oWDataA),
        .oDescValid (oDescValid),
        .iDescReady (iDescReady),
        .oDescAddr  (oDescAddr),
        .oDescLen   (oDescLen),
        .iFreeValid (iFreeValid),
        .iFreeWords (iFreeWords),
        .oFreeWords (oFreeWords),
        .oDropCnt   (oDropCnt)
    );

    always #5 iClk = ~iClk;

    typedef struct { logic [13:0] a; logic [15:0] d; logic [15:0] be; } wr_t;
    typedef struct { logic [13:0] a; logic [11:0] len; } dsc_t;

    wr_t         wq[$];
    dsc_t        dq[$];
    logic [15:0] fdat[$];
    int          pending[$];

    int nChecks = 0;
    int nFails  = 0;
    int mPtr    = 0;
    int mFree   = DEPTH;
    int mDrop   = 0;
    int lastDescAddr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        nChecks++;
        nFails++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic int sat(input int v);
        return (v > DEPTH) ? DEPTH : v;
    endfunction

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    wr_t  mw;
    always @(negedge iClk) begin
        if (oCEnA == 1'b0) begin
            if (wq.size() == 0) begin
                failNow("unexpected_sram_write");
            end else begin
                mw = wq.pop_front();
                check("sram_write{wen,addr,data,bwen}",
                      {oWEnA, oAddrA, oWDataA, oBWEnA}, {1'b0, mw.a, mw.d, mw.be});
            end
        end
        if (oDescValid == 1'b1) begin
            if (dq.size() == 0) begin
                failNow("unexpected_descriptor");
            end else begin
                check("descriptor{addr,len}", {oDescAddr, oDescLen}, {dq[0].a, dq[0].len});
                if (iDescReady) void'(dq.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic beat(input logic [15:0] d, input bit sop, input bit eop, input bit odd);
        int n;
        iValid = 1'b1; iData = d; iSop = sop; iEop = eop; iOdd = odd;
        n = 0;
        while (oReady !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        if (n >= 50) failNow("ready_timeout");
        tick;
        iValid = 1'b0; iSop = 1'b0; iEop = 1'b0; iOdd = 1'b0;
        iData = 16'($urandom);
    endtask

    task automatic releaseWords(input int n);
        iFreeValid = 1'b1;
        iFreeWords = 11'(n);
        tick;
        iFreeValid = 1'b0;
        mFree = sat(mFree + n);
    endtask

    task automatic randomData(input int len);
        fdat.delete();
        for (int i = 0; i < len; i++) fdat.push_back(16'($urandom));
    endtask

    // Sends the frame held in fdat; the model decides admission/abort.
    task automatic sendFrame(input int maxGap, input int readyDelay, input int rel, input bit odd);
        int   len;
        bit   admit;
        bit   over;
        wr_t  w;
        dsc_t ds;
        len   = fdat.size();
        admit = (mFree >= MAXW);
        over  = (len > MAXW);
        if (admit) begin
            for (int i = 0; i < len && i < MAXW; i++) begin
                w.a  = 14'((mPtr + i) % DEPTH);
                w.d  = fdat[i];
                w.be = (odd && i == len - 1) ? 16'h00ff : 16'h0000;
                wq.push_back(w);
            end
            if (!over) begin
                ds.a   = 14'(mPtr);
                ds.len = 12'(2 * len - (odd ? 1 : 0));
                dq.push_back(ds);
            end
        end
        for (int i = 0; i < len; i++) begin
            if (maxGap > 0) repeat ($urandom_range(0, maxGap)) tick;
            beat(fdat[i], i == 0, i == len - 1, odd && (i == len - 1));
        end
        if (admit && !over) begin
            check("desc_valid_after_eop", oDescValid, 1);
            lastDescAddr = int'(oDescAddr);
            for (int k = 0; k < readyDelay; k++) begin
                check("ready_low_in_desc", oReady, 0);
                tick;
            end
            iDescReady = 1'b1;
            if (rel > 0) begin
                iFreeValid = 1'b1;
                iFreeWords = 11'(rel);
            end
            tick;
            iDescReady = 1'b0;
            iFreeValid = 1'b0;
            check("desc_valid_cleared", oDescValid, 0);
            mPtr  = (mPtr + len) % DEPTH;
            mFree = sat(mFree - len + rel);
            pending.push_back(len);
        end else if (mDrop < 65535) begin
            mDrop++;
        end
        check("free_words", oFreeWords, mFree);
        check("drop_cnt", oDropCnt, mDrop);
    endtask

    task automatic releaseAll;
        while (pending.size() > 0) releaseWords(pending.pop_front());
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        int abortStart;
        int freeBefore;
        int rel;

        repeat (3) tick;
        check("rst_ready",      oReady, 0);
        check("rst_cen",        oCEnA, 1);
        check("rst_wen",        oWEnA, 1);
        check("rst_bwen",       oBWEnA, 16'hffff);
        check("rst_addr",       oAddrA, 0);
        check("rst_wdata",      oWDataA, 0);
        check("rst_desc_valid", oDescValid, 0);
        check("rst_desc_addr",  oDescAddr, 0);
        check("rst_desc_len",   oDescLen, 0);
        check("rst_free",       oFreeWords, 16384);
        check("rst_drop",       oDropCnt, 0);
        iRst = 1'b0;
        tick;
        check("ready_idle", oReady, 1);

        // Single frame
        fdat.delete();
        fdat.push_back(16'h1234); fdat.push_back(16'h5678); fdat.push_back(16'hdead);
        sendFrame(0, 0, 0, 1'b0);
        check("single_free_16381", oFreeWords, 16381);

        // Odd-length frame
        fdat.delete();
        fdat.push_back(16'h0a0b); fdat.push_back(16'hbeef);
        sendFrame(1, 1, 0, 1'b1);

        // Randomised frames, stray non-SOP beats, interleaved releases
        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 3) == 0) beat(16'($urandom), 1'b0, 1'b0, 1'b0);
            randomData($urandom_range(1, 20));
            sendFrame(2, $urandom_range(0, 3), 0, 1'($urandom_range(0, 1)));
            if (pending.size() > 0 && $urandom_range(0, 1) == 1) releaseWords(pending.pop_front());
        end
        releaseAll();
        check("free_after_release_all", oFreeWords, mFree);

        // Fill until exactly 1000 words are free
        for (int f = 0; f < 15; f++) begin
            randomData(1024);
            sendFrame(0, 0, 0, 1'b0);
        end
        randomData(24);
        sendFrame(0, 0, 0, 1'b0);
        check("fill_free_1000", oFreeWords, 1000);

        // Admission drop, then a release just before SOP re-enables admission.
        // The admitted frame is sized to leave the write pointer at 16382.
        randomData(5);
        sendFrame(0, 0, 0, 1'b0);
        check("admission_drop_cnt_1", oDropCnt, 1);
        releaseWords(24);
        k = (16382 - mPtr + DEPTH) % DEPTH;
        randomData(k);
        sendFrame(0, 0, 0, 1'b0);
        while (mFree < 3000 && pending.size() > 0) releaseWords(pending.pop_front());

        // Wrap-around frame
        randomData(4);
        sendFrame(1, 0, 0, 1'b0);
        check("wrap_desc_addr", lastDescAddr, 16382);

        // Oversize abort
        abortStart = mPtr;
        randomData(1030);
        sendFrame(0, 0, 0, 1'b0);

        // Descriptor backpressure with a coincident release
        freeBefore = int'(oFreeWords);
        randomData(10);
        sendFrame(0, 5, 100, 1'b0);
        check("simultaneous_free_delta", int'(oFreeWords) - freeBefore, 90);
        check("after_abort_desc_addr", lastDescAddr, abortStart);

        // Saturation of free space
        releaseAll();
        releaseWords(500);
        check("free_saturated", oFreeWords, 16384);

        // More random frames with coincident releases
        for (int f = 0; f < 10; f++) begin
            rel = 0;
            if (pending.size() > 0 && $urandom_range(0, 1) == 1) rel = pending.pop_front();
            randomData($urandom_range(1, 40));
            sendFrame(2, $urandom_range(0, 4), rel, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a frame
        randomData(3);
        for (int i = 0; i < 3; i++) begin
            wq.push_back('{a: 14'((mPtr + i) % DEPTH), d: fdat[i], be: 16'h0000});
            beat(fdat[i], i == 0, 1'b0, 1'b0);
        end
        iRst = 1'b1;
        tick;
        tick;
        check("ready_low_in_reset", oReady, 0);
        iRst = 1'b0;
        mPtr = 0; mFree = DEPTH; mDrop = 0; pending.delete();
        tick;
        check("midrst_free", oFreeWords, 16384);
        check("midrst_drop", oDropCnt, 0);
        check("midrst_desc_valid", oDescValid, 0);
        check("midrst_cen", oCEnA, 1);
        randomData(3);
        sendFrame(0, 0, 0, 1'b1);
        check("post_reset_desc_addr", lastDescAddr, 0);

        repeat (5) tick;
        check("write_queue_drained", wq.size(), 0);
        check("desc_queue_drained", dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
